// File: rtl/latch_word_tx_if.sv
// latch_word_tx_if: word handshake plus the (D, C) latch-drive pair of latch_word_tx.
interface latch_word_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             D;
    logic             C;
    logic             busy;
    logic             done;
    modport master (output data, valid, input ready, D, C, busy, done);
    modport slave  (input data, valid, output ready, D, C, busy, done);
endinterface

// File: rtl/latch_word_tx.sv
// latch_word_tx: shifts a word LSB first onto (D, C) so a D-latch chain captures each bit.
module latch_word_tx #(
    parameter int WIDTH       = 8,
    parameter int HALF_PERIOD = 2
) (
    input logic             clk,
    input logic             rst,
    latch_word_tx_if.slave  bus
);
    localparam int PW = $clog2(HALF_PERIOD + 1);
    localparam int BW = $clog2(WIDTH);
    localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, c_q, c_d, d_q, d_d;
    logic             fire;

    assign fire = bus.valid && ready_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = fire ? SETUP : IDLE;
                if (fire) begin
                    sh_d    = bus.data;
                    bit_d   = '0;
                    phase_d = '0;
                end
            end
            SETUP: begin
                state_d = (phase_q == PH_LAST) ? STROBE : SETUP;
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            end
            STROBE: begin
                state_d = (phase_q == PH_LAST) ? HOLD : STROBE;
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            end
            HOLD: begin
                state_d = (bit_q == BIT_LAST) ? DONE : SETUP;
                if (bit_q != BIT_LAST) begin
                    sh_d    = sh_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    phase_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state, so D only moves on SETUP entry
        ready_d = (state_d == IDLE) || (state_d == DONE);
        busy_d  = !ready_d;
        done_d  = state_d == DONE;
        c_d     = state_d == STROBE;
        d_d     = busy_d && sh_d[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= 1'b0;
            d_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.C     = c_q;
    assign bus.D     = d_q;
endmodule

// File: tb/tb_latch_word_tx.sv
// tb_latch_word_tx: random and directed frames checked against a cycle-offset reference and a latch receiver.
module tb_latch_word_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    latch_word_tx_if #(.WIDTH(8)) ba ();
    latch_word_tx_if #(.WIDTH(4)) bb ();

    latch_word_tx #(.WIDTH(8), .HALF_PERIOD(2)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
    latch_word_tx #(.WIDTH(4), .HALF_PERIOD(1)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ready, busy, done, C, D}
    function automatic logic [4:0] obs(input int which);
        return which == 0 ? {ba.ready, ba.busy, ba.done, ba.C, ba.D}
                          : {bb.ready, bb.busy, bb.done, bb.C, bb.D};
    endfunction

    // Expected outputs t cycles after the handshake edge, from bit-period arithmetic.
    function automatic logic [4:0] model(input logic [7:0] w, input int W, input int H, input int t);
        int p, i, r;
        p = 2 * H + 1;
        if (t > W * p) return 5'b10100;
        i = (t - 1) / p;
        r = (t - 1) % p;
        return {1'b0, 1'b1, 1'b0, (r >= H && r < 2 * H), w[i]};
    endfunction

    task automatic drive(input int which, input logic v, input logic [7:0] d);
        if (which == 0) begin
            ba.valid = v;
            ba.data  = d;
        end else begin
            bb.valid = v;
            bb.data  = d[3:0];
        end
    endtask

    // Caller has valid/data set and sits just after an edge; the next edge is the handshake.
    task automatic frame(input int which, input int W, input int H, input logic [7:0] w,
                         input logic nv, input logic [7:0] nd);
        int fl, pulses;
        logic [7:0] rx, sel;
        logic pc, pd;
        logic [4:0] o;
        fl = W * (2 * H + 1);
        o = obs(which);
        chk("hs_ready", o[4], 1'b1);
        @(posedge clk);
        #1;
        drive(which, nv, nd);
        rx = 8'h00;
        sel = 8'h01;
        pc = 1'b0;
        pd = 1'b0;
        pulses = 0;
        for (int t = 1; t <= fl + 1; t++) begin
            o = obs(which);
            chk("frame_out", o, model(w, W, H, t));
            if (pc) chk("d_stable", o[0], pd);
            if (o[1]) rx = (rx & ~sel) | (o[0] ? sel : 8'h00);
            if (pc && !o[1]) begin
                sel = sel << 1;
                pulses++;
            end
            pc = o[1];
            pd = o[0];
            if (t <= fl) begin
                @(posedge clk);
                #1;
            end
        end
        chk("pulses", pulses, W);
        chk("rx_word", rx, w);
    endtask

    task automatic idle_cycles(input int n);
        logic [4:0] o;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            o = obs(0);
            chk("idle_a", o, 5'b10000);
        end
    endtask

    initial begin
        logic [4:0] o;
        logic [7:0] w;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        #1 rst = 1'b1;
        #1;
        o = obs(0);
        chk("rst_a", o, 5'b10000);
        o = obs(1);
        chk("rst_b", o, 5'b10000);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(2);

        drive(0, 1'b1, 8'hA5);
        frame(0, 8, 2, 8'hA5, 1'b0, 8'h00);
        idle_cycles(1);
        drive(0, 1'b1, 8'h00);
        frame(0, 8, 2, 8'h00, 1'b0, 8'h00);
        drive(0, 1'b1, 8'hFF);
        frame(0, 8, 2, 8'hFF, 1'b0, 8'h00);
        idle_cycles(2);
        drive(0, 1'b1, 8'h5A);
        frame(0, 8, 2, 8'h5A, 1'b0, 8'h00);
        idle_cycles(1);

        drive(0, 1'b1, 8'h3C);
        frame(0, 8, 2, 8'h3C, 1'b1, 8'hC3);
        frame(0, 8, 2, 8'hC3, 1'b0, 8'h00);
        idle_cycles(1);

        drive(0, 1'b1, 8'hFF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h00);
        repeat (17) begin
            @(posedge clk);
            #1;
        end
        o = obs(0);
        chk("bit3_strobe", o, 5'b01011);
        #2 rst = 1'b1;
        #1;
        o = obs(0);
        chk("rst_mid_frame", o, 5'b10000);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(45);
        drive(0, 1'b1, 8'h81);
        frame(0, 8, 2, 8'h81, 1'b0, 8'h00);

        for (int n = 0; n < 50; n++) begin
            idle_cycles($urandom_range(0, 3));
            w = 8'($urandom);
            drive(0, 1'b1, w);
            frame(0, 8, 2, w, 1'b0, 8'h00);
        end

        @(posedge clk);
        #1;
        drive(1, 1'b1, 8'h09);
        frame(1, 4, 1, 8'h09, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        o = obs(1);
        chk("idle_b", o, 5'b10000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
